// File: rtl/seg_scan_pkg.sv
// Shared types and sizing for the seven-segment scan sequencer.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   localparam int DIGITS = 8;

   // Counter must hold the larger of DWELL-1 and BLANK_CYC-1.
   function automatic int cnt_width(input int dwell, input int blank_cyc);
      int m;
      m = (dwell > blank_cyc) ? dwell : blank_cyc;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter with a zero flag, shared by the SHOW and BLANK phases.
module seg_scan_timer #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   output logic          o_zero
);

   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - ONE;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan sequencer for an 8-digit multiplexed seven-segment display with frame-consistent shadows.
// Optional macro SEG_BLINK_EN adds blink_mask and a frame counter for per-digit blinking.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int DWELL     = 50000,
   parameter int BLANK_CYC = 64,
   parameter int BLINK_SH  = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        upd_req,
   input  logic [31:0] Hexs_in,
   input  logic [7:0]  point_in,
   input  logic [7:0]  LES_in,
`ifdef SEG_BLINK_EN
   input  logic [7:0]  blink_mask,
`endif
   output logic        upd_ack,
   output logic [2:0]  Scan,
   output logic [31:0] Hexs,
   output logic [7:0]  point,
   output logic [7:0]  LES,
   output logic        blank,
   output logic        frame_done
);

   localparam int             CW         = cnt_width(DWELL, BLANK_CYC);
   localparam logic [CW-1:0]  DWELL_LD   = CW'(DWELL - 1);
   localparam logic [CW-1:0]  BLANK_LD   = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam logic [2:0]     LAST_DIGIT = 3'(DIGITS - 1);

   state_t        r_state;
   logic [2:0]    r_scan;
   logic [31:0]   r_hexs;
   logic [7:0]    r_point;
   logic [7:0]    r_les;
   logic          r_blank;
   logic          r_upd_ack;
   logic          r_frame_done;

   state_t        w_next_state;
   logic [2:0]    w_next_scan;
   logic          w_clr;
   logic          w_load;
   logic [CW-1:0] w_load_val;
   logic          w_zero;
   logic          w_wrap;
   logic          w_bound;
   logic          w_upd;
   logic          w_blink_off;
   logic          w_next_blank;

   seg_scan_timer #(.CW(CW)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_clr),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_next_state = r_state;
      w_next_scan  = r_scan;
      w_clr        = 1'b0;
      w_load       = 1'b0;
      w_load_val   = DWELL_LD;
      w_wrap       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_next_scan = 3'd0;
            if (en) begin
               w_next_state = ST_SHOW;
               w_load       = 1'b1;
            end else begin
               w_clr = 1'b1;
            end
         end
         ST_SHOW: begin
            if (!en) begin
               w_next_state = ST_IDLE;
               w_next_scan  = 3'd0;
               w_clr        = 1'b1;
            end else if (w_zero) begin
               w_load = 1'b1;
               if (BLANK_CYC > 0) begin
                  w_next_state = ST_BLANK;
                  w_load_val   = BLANK_LD;
               end else begin
                  w_next_scan = r_scan + 3'd1;
                  w_wrap      = (r_scan == LAST_DIGIT);
               end
            end
         end
         ST_BLANK: begin
            if (!en) begin
               w_next_state = ST_IDLE;
               w_next_scan  = 3'd0;
               w_clr        = 1'b1;
            end else if (w_zero) begin
               w_next_state = ST_SHOW;
               w_next_scan  = r_scan + 3'd1;
               w_load       = 1'b1;
               w_wrap       = (r_scan == LAST_DIGIT);
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_scan  = 3'd0;
            w_clr        = 1'b1;
         end
      endcase
   end

   // Boundary ignores en so a request still loads when en falls on the wrap cycle.
   assign w_bound = ((r_state == ST_BLANK) || ((r_state == ST_SHOW) && (BLANK_CYC == 0)))
                    && w_zero && (r_scan == LAST_DIGIT);
   assign w_upd   = upd_req && !r_upd_ack && ((r_state == ST_IDLE) || w_bound);

`ifdef SEG_BLINK_EN
   logic [15:0] r_fc;
   logic [15:0] w_fc_next;

   assign w_fc_next   = r_fc + {15'd0, w_wrap};
   assign w_blink_off = blink_mask[w_next_scan] & w_fc_next[BLINK_SH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fc <= 16'd0;
      end else begin
         r_fc <= w_fc_next;
      end
   end
`else
   assign w_blink_off = 1'b0;
`endif

   // Blink decision is latched only on digit entry, so mask changes apply from the next digit.
   always_comb begin
      w_next_blank = r_blank;
      if (w_next_state != ST_SHOW) begin
         w_next_blank = 1'b1;
      end else if (w_load) begin
         w_next_blank = w_blink_off;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_scan       <= 3'd0;
         r_hexs       <= 32'h0;
         r_point      <= 8'hFF;
         r_les        <= 8'hFF;
         r_blank      <= 1'b1;
         r_upd_ack    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_scan       <= w_next_scan;
         r_blank      <= w_next_blank;
         r_frame_done <= w_wrap;
         r_upd_ack    <= w_upd;
         if (w_upd) begin
            r_hexs  <= Hexs_in;
            r_point <= point_in;
            r_les   <= LES_in;
         end
      end
   end

   assign Scan       = r_scan;
   assign Hexs       = r_hexs;
   assign point      = r_point;
   assign LES        = r_les;
   assign blank      = r_blank;
   assign upd_ack    = r_upd_ack;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl (blink checks only when SEG_BLINK_EN is defined).
module tb_seg_scan_ctrl;

   typedef struct {
      int         cyc;
      logic [2:0] scan;
      logic       blank;
      logic       fd;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        en_b;
   logic        upd_req;
   logic        upd_req_b;
   logic [31:0] Hexs_in;
   logic [7:0]  point_in;
   logic [7:0]  LES_in;
   logic [7:0]  blink_mask;

   logic        upd_ack, blank, frame_done;
   logic [2:0]  Scan;
   logic [31:0] Hexs;
   logic [7:0]  point, LES;

   logic        upd_ack_b, blank_b, frame_done_b;
   logic [2:0]  scan_b;
   logic [31:0] hexs_b;
   logic [7:0]  point_b, les_b;

   int n_pass;
   int n_total;

   vec_t tbl_a[13];
   vec_t tbl_b[6];
   vec_t tbl_k[5];

   seg_scan_ctrl #(.DWELL(4), .BLANK_CYC(2), .BLINK_SH(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .upd_req    (upd_req),
      .Hexs_in    (Hexs_in),
      .point_in   (point_in),
      .LES_in     (LES_in),
`ifdef SEG_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .upd_ack    (upd_ack),
      .Scan       (Scan),
      .Hexs       (Hexs),
      .point      (point),
      .LES        (LES),
      .blank      (blank),
      .frame_done (frame_done)
   );

   seg_scan_ctrl #(.DWELL(3), .BLANK_CYC(0), .BLINK_SH(0)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en_b),
      .upd_req    (upd_req_b),
      .Hexs_in    (Hexs_in),
      .point_in   (point_in),
      .LES_in     (LES_in),
`ifdef SEG_BLINK_EN
      .blink_mask (8'h00),
`endif
      .upd_ack    (upd_ack_b),
      .Scan       (scan_b),
      .Hexs       (hexs_b),
      .point      (point_b),
      .LES        (les_b),
      .blank      (blank_b),
      .frame_done (frame_done_b)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial begin
      int fd_cnt;
      int idx;
      int viol;
      bit found;

      n_pass = 0;
      n_total = 0;

      // DWELL=4, BLANK_CYC=2: digit period 6, frame 48; k = edges after en rose.
      tbl_a[0]  = '{1,  3'd0, 1'b0, 1'b0};
      tbl_a[1]  = '{4,  3'd0, 1'b0, 1'b0};
      tbl_a[2]  = '{5,  3'd0, 1'b1, 1'b0};
      tbl_a[3]  = '{6,  3'd0, 1'b1, 1'b0};
      tbl_a[4]  = '{7,  3'd1, 1'b0, 1'b0};
      tbl_a[5]  = '{11, 3'd1, 1'b1, 1'b0};
      tbl_a[6]  = '{13, 3'd2, 1'b0, 1'b0};
      tbl_a[7]  = '{25, 3'd4, 1'b0, 1'b0};
      tbl_a[8]  = '{42, 3'd6, 1'b1, 1'b0};
      tbl_a[9]  = '{43, 3'd7, 1'b0, 1'b0};
      tbl_a[10] = '{48, 3'd7, 1'b1, 1'b0};
      tbl_a[11] = '{49, 3'd0, 1'b0, 1'b1};
      tbl_a[12] = '{50, 3'd0, 1'b0, 1'b0};

      // DWELL=3, BLANK_CYC=0: digit period 3, frame 24.
      tbl_b[0] = '{1,  3'd0, 1'b0, 1'b0};
      tbl_b[1] = '{3,  3'd0, 1'b0, 1'b0};
      tbl_b[2] = '{4,  3'd1, 1'b0, 1'b0};
      tbl_b[3] = '{22, 3'd7, 1'b0, 1'b0};
      tbl_b[4] = '{24, 3'd7, 1'b0, 1'b0};
      tbl_b[5] = '{25, 3'd0, 1'b0, 1'b1};

      // Blink with mask 8'h01, BLINK_SH=0: digit 0 dark on odd frames.
      tbl_k[0] = '{1,  3'd0, 1'b0, 1'b0};
      tbl_k[1] = '{7,  3'd1, 1'b0, 1'b0};
      tbl_k[2] = '{49, 3'd0, 1'b1, 1'b1};
      tbl_k[3] = '{55, 3'd1, 1'b0, 1'b0};
      tbl_k[4] = '{97, 3'd0, 1'b0, 1'b1};

      rst_n      = 1'b0;
      en         = 1'b0;
      en_b       = 1'b0;
      upd_req    = 1'b0;
      upd_req_b  = 1'b0;
      Hexs_in    = 32'h0;
      point_in   = 8'h00;
      LES_in     = 8'h00;
      blink_mask = 8'h00;

      // reset values
      repeat (3) step();
      chk("rst_scan",  {29'd0, Scan}, 32'd0);
      chk("rst_hexs",  Hexs, 32'h0);
      chk("rst_point", {24'd0, point}, 32'hFF);
      chk("rst_les",   {24'd0, LES}, 32'hFF);
      chk("rst_blank", {31'd0, blank}, 32'd1);
      chk("rst_ack",   {31'd0, upd_ack}, 32'd0);
      chk("rst_fd",    {31'd0, frame_done}, 32'd0);
      chk("rst_b_point", {24'd0, point_b}, 32'hFF);

      // scan sequence over two frames
      rst_n = 1'b1;
      en    = 1'b1;
      fd_cnt = 0;
      idx = 0;
      for (int k = 1; k <= 97; k++) begin
         step();
         if (frame_done) fd_cnt++;
         if (idx < 13 && tbl_a[idx].cyc == k) begin
            chk($sformatf("seq_scan_k%0d", k),  {29'd0, Scan}, {29'd0, tbl_a[idx].scan});
            chk($sformatf("seq_blank_k%0d", k), {31'd0, blank}, {31'd0, tbl_a[idx].blank});
            chk($sformatf("seq_fd_k%0d", k),    {31'd0, frame_done}, {31'd0, tbl_a[idx].fd});
            idx++;
         end
      end
      chk("fd_count", fd_cnt, 2);

      // mid-frame update raised at Scan=3; shadows hold until the 7->0 edge (k=145)
      repeat (18) step();
      chk("upd_at_scan3", {29'd0, Scan}, 32'd3);
      upd_req  = 1'b1;
      Hexs_in  = 32'h89ABCDEF;
      point_in = 8'h55;
      LES_in   = 8'hA5;
      viol = 0;
      for (int k = 116; k <= 144; k++) begin
         step();
         if (Hexs !== 32'h0 || upd_ack !== 1'b0) viol++;
      end
      chk("upd_hold_old", viol, 0);
      step();
      chk("upd_ack",   {31'd0, upd_ack}, 32'd1);
      chk("upd_hexs",  Hexs, 32'h89ABCDEF);
      chk("upd_point", {24'd0, point}, 32'h55);
      chk("upd_les",   {24'd0, LES}, 32'hA5);
      chk("upd_fd",    {31'd0, frame_done}, 32'd1);
      chk("upd_scan",  {29'd0, Scan}, 32'd0);
      // request still high during the ack cycle must not load again
      Hexs_in = 32'hDEADBEEF;
      step();
      chk("upd_ack_once", {31'd0, upd_ack}, 32'd0);
      chk("upd_no_reload", Hexs, 32'h89ABCDEF);
      upd_req = 1'b0;

      // enable dropped at Scan=5 in SHOW
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         if (Scan == 3'd5 && blank == 1'b0) found = 1'b1;
      end
      chk("wait_scan5", {31'd0, found}, 32'd1);
      en = 1'b0;
      step();
      chk("drop_scan",  {29'd0, Scan}, 32'd0);
      chk("drop_blank", {31'd0, blank}, 32'd1);
      chk("drop_fd",    {31'd0, frame_done}, 32'd0);
      step();
      chk("idle_blank", {31'd0, blank}, 32'd1);

      // update while idle
      upd_req  = 1'b1;
      point_in = 8'h0F;
      Hexs_in  = 32'h12345678;
      LES_in   = 8'h3C;
      step();
      chk("idle_ack",   {31'd0, upd_ack}, 32'd1);
      chk("idle_point", {24'd0, point}, 32'h0F);
      chk("idle_hexs",  Hexs, 32'h12345678);
      chk("idle_les",   {24'd0, LES}, 32'h3C);
      chk("idle_blank_upd", {31'd0, blank}, 32'd1);
      upd_req = 1'b0;
      step();
      chk("idle_ack_low", {31'd0, upd_ack}, 32'd0);

      // reset in mid-operation
      en = 1'b1;
      repeat (10) step();
      rst_n = 1'b0;
      step();
      chk("mrst_scan",  {29'd0, Scan}, 32'd0);
      chk("mrst_hexs",  Hexs, 32'h0);
      chk("mrst_point", {24'd0, point}, 32'hFF);
      chk("mrst_les",   {24'd0, LES}, 32'hFF);
      chk("mrst_blank", {31'd0, blank}, 32'd1);
      rst_n = 1'b1;
      en    = 1'b0;
      step();

      // no dead-time instance
      en_b = 1'b1;
      idx = 0;
      viol = 0;
      for (int k = 1; k <= 48; k++) begin
         step();
         if (blank_b !== 1'b0) viol++;
         if (idx < 6 && tbl_b[idx].cyc == k) begin
            chk($sformatf("nb_scan_k%0d", k), {29'd0, scan_b}, {29'd0, tbl_b[idx].scan});
            chk($sformatf("nb_fd_k%0d", k),   {31'd0, frame_done_b}, {31'd0, tbl_b[idx].fd});
            idx++;
         end
      end
      chk("nb_never_blank", viol, 0);
      chk("nb_no_ack", {31'd0, upd_ack_b}, 32'd0);
      chk("nb_hexs", hexs_b, 32'h0);
      chk("nb_les", {24'd0, les_b}, 32'hFF);
      en_b = 1'b0;

`ifdef SEG_BLINK_EN
      rst_n = 1'b0;
      step();
      rst_n      = 1'b1;
      blink_mask = 8'h01;
      en         = 1'b1;
      idx = 0;
      for (int k = 1; k <= 97; k++) begin
         step();
         if (idx < 5 && tbl_k[idx].cyc == k) begin
            chk($sformatf("blink_scan_k%0d", k),  {29'd0, Scan}, {29'd0, tbl_k[idx].scan});
            chk($sformatf("blink_blank_k%0d", k), {31'd0, blank}, {31'd0, tbl_k[idx].blank});
            chk($sformatf("blink_fd_k%0d", k),    {31'd0, frame_done}, {31'd0, tbl_k[idx].fd});
            idx++;
         end
      end
      en = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
